mc_controller: RTL
==================

# mc_controller

Multicycle control unit for the 32-bit ARM-subset processor. It decodes the latched instruction, walks a per-instruction state machine, and evaluates the ARM condition field against an internal NZCV flag register. It drives the multicycle datapath's enables and mux selects, so the core shares one memory port and one ALU across cycles.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `Instr`  in  32  instruction register contents. Uses Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU in the current cycle
- `MemReady`  in  1  memory completion; used only when `MC_CTRL_MEMWAIT_EN` is defined
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result
- `MemWrite`  out  1  data memory write strobe
- `IRWrite`  out  1  instruction register enable
- `RegWrite`  out  1  register file write enable
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  1  0 = register A, 1 = PC
- `ALUSrcB`  out  2  00 = register B, 01 = ExtImm, 10 = constant 4
- `ALUControl`  out  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR
- `ImmSrc`  out  2  Op field passed through to the extender
- `RegSrc`  out  2  bit0 = (Op==10), bit1 = (Op==01)

## Operation
- States, encoded in order 0–9: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR when Op=01.
  - DECODE→EXECR when Op=00 and Funct[5]=0.
  - DECODE→EXECI when Op=00 and Funct[5]=1.
  - DECODE→BRANCH when Op=10.
  - DECODE→FETCH when Op=11 (undefined opcode; treated as NOP).
  - MEMADR→MEMREAD when Funct[0]=1, otherwise →MEMWRITE.
  - MEMREAD→MEMWB→FETCH. MEMWRITE→FETCH.
  - EXECR/EXECI→ALUWB→FETCH. BRANCH→FETCH.
- Per-state outputs. Every output not listed is 0 (`ImmSrc` and `RegSrc` are always decoded from `Instr`).
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - MEMADR: ALUSrcB=01, ADD.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=CondEx.
  - MEMWRITE: AdrSrc=1, MemWrite=CondEx.
  - EXECR: ALUSrcB=00, ALU operation decoded.
  - EXECI: ALUSrcB=01, ALU operation decoded.
  - ALUWB: RegWrite = CondEx & ~NoWrite.
  - BRANCH: ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx.
- ALU decode uses Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB with NoWrite=1). Any other value decodes as ADD.
- Flag update:
  - Happens at the end of EXECR/EXECI when Funct[0]=1 and CondEx=1.
  - N and Z update for every data-processing op.
  - C and V update only for ADD, SUB and CMP.
- Writeback to PC: in MEMWB/ALUWB with Rd=15 and the write enabled, PCWrite=1 as well.
- CondEx is evaluated from Cond and the stored flags (never the live `ALUFlags`):
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z.
  - GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 → 0.

## Timing
- Reset:
  - On the edge that samples reset=1, state becomes FETCH and flags become 0000.
  - While reset=1, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0 regardless of state.
  - Reset mid-instruction abandons the instruction with no partial writes after that point.
- Select outputs are Moore (a function of state and `Instr` only). Write strobes add combinational CondEx gating.
- Cycles per instruction without wait states: LDR 5, STR 4, data-processing 4, B 3, undefined 2.
- Flags written in cycle N are visible to CondEx from cycle N+1. A CMP immediately followed by a conditional instruction uses the updated flags.

## Configuration
- `MC_CTRL_MEMWAIT_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold their state while MemReady=0.
  - In FETCH, IRWrite and PCWrite assert only in the cycle where MemReady=1.
  - In MEMWRITE, MemWrite stays asserted (CondEx-gated) for every cycle in the state.
  - MEMREAD advances only when MemReady=1.
- Not defined: `MemReady` is ignored and all three states take exactly 1 cycle.

## Structure
- `mc_ctrl_pkg` holds the state enum, the ALUControl codes, the Cond codes and the ResultSrc/ALUSrcB encodings.
- One sub-module, `cond_unit`, contains the flag register, the CondEx evaluation and the gated flag write.
- The FSM and decoder live in `mc_controller`.

## Test plan
- Reset held 2 cycles mid-MEMWRITE → state=FETCH, flags=0000, MemWrite=0 during both reset cycles.
- ADD R1,R2,R3 (0xE0821003) → states FETCH, DECODE, EXECR, ALUWB; ALUControl=00 in EXECR; RegWrite=1 in ALUWB.
- LDR R0,[R1,#4] (0xE5910004) → 5 cycles; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB.
- CMP with ALUFlags=0100 (0xE1500001), then BEQ (0x0A000002) → RegWrite=0 in ALUWB; PCWrite=1 in BRANCH.
- BNE (0x1A000002) after the CMP that set Z → PCWrite=0 in BRANCH; next state FETCH.
- With `MC_CTRL_MEMWAIT_EN`, MemReady=0 for 3 cycles during STR → MEMWRITE held 4 cycles, MemWrite=1 throughout, then FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_ctl_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_t;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_EXT  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // ARM condition evaluation against a {N,Z,C,V} vector.
   function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: return z;
         COND_NE: return ~z;
         COND_CS: return c;
         COND_CC: return ~c;
         COND_MI: return n;
         COND_PL: return ~n;
         COND_VS: return v;
         COND_VC: return ~v;
         COND_HI: return c & ~z;
         COND_LS: return ~c | z;
         COND_GE: return n == v;
         COND_LT: return n != v;
         COND_GT: return ~z & (n == v);
         COND_LE: return z | (n != v);
         COND_AL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_controller_cond_unit.sv
// Condition unit: stored NZCV flags, CondEx evaluation and gated flag write.
module cond_unit
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] i_cond,
   input  logic [3:0] i_alu_flags,
   input  logic [1:0] i_flag_w,     // [1] = N,Z update, [0] = C,V update
   output logic       o_cond_ex
);

   logic [3:0] r_flags;
   logic [1:0] w_flag_we;

   // CondEx always comes from the stored flags, never the live ALU flags.
   assign o_cond_ex = cond_check(i_cond, r_flags);
   assign w_flag_we = i_flag_w & {2{o_cond_ex}};

   // Flag register: N,Z and C,V halves written independently.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags <= 4'b0000;
      end else begin
         if (w_flag_we[1]) r_flags[3:2] <= i_alu_flags[3:2];
         if (w_flag_we[0]) r_flags[1:0] <= i_alu_flags[1:0];
      end
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: instruction decode, per-instruction FSM and
// CondEx-gated write strobes. Optional macro MC_CTRL_MEMWAIT_EN makes
// FETCH/MEMREAD/MEMWRITE wait for MemReady.
module mc_controller
   import mc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   input  logic        MemReady,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic [1:0]  ResultSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUControl,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc
);

   state_t     r_state, w_next;
   logic [1:0] w_op;
   logic [5:0] w_funct;
   logic       w_rd_pc;
   logic       w_cond_ex;
   logic       w_mem_ready;
   alu_ctl_t   w_alu_ctl;
   logic       w_no_write;
   logic       w_cv_upd;
   logic [1:0] w_flag_w;
   logic       w_pc_write, w_mem_write, w_ir_write, w_reg_write;

   assign w_op    = Instr[27:26];
   assign w_funct = Instr[25:20];
   assign w_rd_pc = (Instr[15:12] == 4'd15);

`ifdef MC_CTRL_MEMWAIT_EN
   assign w_mem_ready = MemReady;
   logic w_unused;
   assign w_unused = ^{Instr[19:16], Instr[11:0]};
`else
   assign w_mem_ready = 1'b1;
   logic w_unused;
   assign w_unused = ^{MemReady, Instr[19:16], Instr[11:0]};
`endif

   assign ImmSrc = w_op;
   assign RegSrc = {w_op == OP_MEM, w_op == OP_BR};

   cond_unit u_cond (
      .clk         (clk),
      .reset       (reset),
      .i_cond      (Instr[31:28]),
      .i_alu_flags (ALUFlags),
      .i_flag_w    (w_flag_w),
      .o_cond_ex   (w_cond_ex)
   );

   // ALU operation decode from cmd field; CMP is a SUB that never writes back.
   always_comb begin
      w_alu_ctl  = ALU_ADD;
      w_no_write = 1'b0;
      w_cv_upd   = 1'b1;
      case (w_funct[4:1])
         4'b0100: w_alu_ctl = ALU_ADD;
         4'b0010: w_alu_ctl = ALU_SUB;
         4'b0000: begin w_alu_ctl = ALU_AND; w_cv_upd = 1'b0; end
         4'b1100: begin w_alu_ctl = ALU_ORR; w_cv_upd = 1'b0; end
         4'b1010: begin w_alu_ctl = ALU_SUB; w_no_write = 1'b1; end
         default: w_alu_ctl = ALU_ADD;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   // Next-state logic, Moore selects and ungated write strobes.
   always_comb begin
      w_next      = r_state;
      w_pc_write  = 1'b0;
      w_mem_write = 1'b0;
      w_ir_write  = 1'b0;
      w_reg_write = 1'b0;
      w_flag_w    = 2'b00;
      AdrSrc      = 1'b0;
      ResultSrc   = RES_ALUOUT;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      ALUControl  = ALU_ADD;
      case (r_state)
         S_FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            if (w_mem_ready) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               w_next     = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            case (w_op)
               OP_MEM:  w_next = S_MEMADR;
               OP_DP:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
               OP_BR:   w_next = S_BRANCH;
               default: w_next = S_FETCH;   // undefined opcode: NOP
            endcase
         end
         S_MEMADR: begin
            ALUSrcB = SRCB_EXT;
            w_next  = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (w_mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc   = RES_DATA;
            w_reg_write = w_cond_ex;
            w_pc_write  = w_cond_ex & w_rd_pc;
            w_next      = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc      = 1'b1;
            w_mem_write = w_cond_ex;
            if (w_mem_ready) w_next = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            ALUSrcB    = (r_state == S_EXECI) ? SRCB_EXT : SRCB_REG;
            ALUControl = w_alu_ctl;
            w_flag_w   = {w_funct[0], w_funct[0] & w_cv_upd};
            w_next     = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_write = w_cond_ex & ~w_no_write;
            w_pc_write  = w_cond_ex & ~w_no_write & w_rd_pc;
            w_next      = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcB    = SRCB_EXT;
            ResultSrc  = RES_ALURESULT;
            w_pc_write = w_cond_ex;
            w_next     = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Reset suppresses every architectural write immediately.
   assign PCWrite  = w_pc_write  & ~reset;
   assign MemWrite = w_mem_write & ~reset;
   assign IRWrite  = w_ir_write  & ~reset;
   assign RegWrite = w_reg_write & ~reset;

endmodule
